// File: rtl/gpu_mem_responder.sv
// Single-beat SRAM responder for the GPU memory controller's req/ack port.
// Adds fixed read/write latency, periodic refresh stalls, and simple counters.
module gpu_mem_responder #(
    parameter int NUM_CHANNELS     = 4,
    parameter int CHANNEL_WIDTH    = 128,
    parameter int ADDR_WIDTH       = 40,
    parameter int DEPTH            = 256,
    parameter int READ_LATENCY     = 4,
    parameter int WRITE_LATENCY    = 2,
    parameter int REFRESH_INTERVAL = 64,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    mem_req,
    input  logic                                    mem_we,
    input  logic [ADDR_WIDTH-1:0]                   mem_addr,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   mem_wdata,
    output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   mem_rdata,
    output logic                                    mem_ack,
    output logic                                    mem_err,
    output logic [31:0]                             access_count,
    output logic [31:0]                             refresh_count
);
    localparam int W       = NUM_CHANNELS * CHANNEL_WIDTH;
    localparam int ALSB    = $clog2(W / 8);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam int RF_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TMR_W   = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((REFRESH_INTERVAL > 0) ? REFRESH_INTERVAL - 1 : 0);

    typedef enum logic [2:0] {IDLE, REFRESH, BUSY, ACK, RECOVER} state_t;

    state_t             state_reg;
    logic [LAT_W-1:0]   lat_cnt_reg;
    logic [RF_W-1:0]    rf_cnt_reg;
    logic [TMR_W-1:0]   tmr_reg;
    logic               refresh_pending_reg;
    logic               we_reg;
    logic               oor_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [W-1:0]       wdata_reg;
    logic [W-1:0]       rd_word_reg;
    logic [W-1:0]       mem_array [DEPTH];

    logic [IDX_W-1:0]   req_idx;
    logic               req_oor;
    logic               write_commit;
    logic               addr_unused;

    assign req_idx     = mem_addr[ALSB +: IDX_W];
    // Byte-lane bits carry no meaning for full-width beats.
    assign addr_unused = ^mem_addr[ALSB-1:0];

    generate
        if (ADDR_WIDTH > ALSB + IDX_W) begin : g_oor
            assign req_oor = |mem_addr[ADDR_WIDTH-1:ALSB+IDX_W];
        end else begin : g_no_oor
            assign req_oor = 1'b0;
        end
    endgenerate

    assign write_commit = (state_reg == BUSY) && (lat_cnt_reg == LAT_W'(1)) && we_reg && !oor_reg;

    // Storage stays unreset so it maps onto block RAM; the read is taken
    // while idle so the word is ready well before the ack edge.
    always_ff @(posedge clk) begin
        if (write_commit) begin
            mem_array[idx_reg] <= wdata_reg;
        end
        if (state_reg == IDLE) begin
            rd_word_reg <= mem_array[req_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg           <= IDLE;
            lat_cnt_reg         <= '0;
            rf_cnt_reg          <= '0;
            tmr_reg             <= '0;
            refresh_pending_reg <= 1'b0;
            we_reg              <= 1'b0;
            oor_reg             <= 1'b0;
            idx_reg             <= '0;
            wdata_reg           <= '0;
            mem_rdata           <= '0;
            mem_ack             <= 1'b0;
            mem_err             <= 1'b0;
            access_count        <= '0;
            refresh_count       <= '0;
        end else begin
            mem_ack <= 1'b0;
            mem_err <= 1'b0;

            if (REFRESH_INTERVAL != 0) begin
                if (tmr_reg == TMR_LAST) begin
                    tmr_reg <= '0;
                end else begin
                    tmr_reg <= tmr_reg + TMR_W'(1);
                end
            end

            case (state_reg)
                IDLE: begin
                    if (refresh_pending_reg) begin
                        refresh_pending_reg <= 1'b0;
                        rf_cnt_reg          <= RF_W'(REFRESH_CYCLES - 1);
                        state_reg           <= REFRESH;
                    end else if (mem_req) begin
                        we_reg      <= mem_we;
                        oor_reg     <= req_oor;
                        idx_reg     <= req_idx;
                        wdata_reg   <= mem_wdata;
                        lat_cnt_reg <= mem_we ? LAT_W'(WRITE_LATENCY) : LAT_W'(READ_LATENCY);
                        state_reg   <= BUSY;
                    end
                end
                REFRESH: begin
                    if (rf_cnt_reg == '0) begin
                        refresh_count <= refresh_count + 32'd1;
                        state_reg     <= IDLE;
                    end else begin
                        rf_cnt_reg <= rf_cnt_reg - RF_W'(1);
                    end
                end
                BUSY: begin
                    // Completes even if the initiator has already dropped mem_req.
                    if (lat_cnt_reg == LAT_W'(1)) begin
                        mem_ack      <= 1'b1;
                        mem_err      <= oor_reg;
                        access_count <= access_count + 32'd1;
                        if (!we_reg) begin
                            mem_rdata <= oor_reg ? '0 : rd_word_reg;
                        end
                        state_reg <= ACK;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
                    end
                end
                ACK:     state_reg <= RECOVER;
                RECOVER: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            // Placed last so a fresh expiry wins over the IDLE clear; a second
            // expiry while still pending simply leaves the flag set.
            if ((REFRESH_INTERVAL != 0) && (tmr_reg == TMR_LAST)) begin
                refresh_pending_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gpu_mem_responder.sv
// Scoreboard bench for gpu_mem_responder: one DUT with refresh, one with refresh disabled.
module tb_gpu_mem_responder;
    localparam int NC = 4, CW = 128, W = NC * CW, AW = 40, DEPTH = 256;
    localparam int RL = 4, WL = 2, RI = 64, RC = 4;
    localparam int ALSB = 6, IDX_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          req_s   [2];
    logic          we_s    [2];
    logic [AW-1:0] addr_s  [2];
    logic [W-1:0]  wdata_s [2];
    logic [W-1:0]  rdata_s [2];
    logic          ack_s   [2];
    logic          err_s   [2];
    logic [31:0]   acc_s   [2];
    logic [31:0]   ref_s   [2];

    gpu_mem_responder #(
        .NUM_CHANNELS(NC), .CHANNEL_WIDTH(CW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL), .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(req_s[0]), .mem_we(we_s[0]), .mem_addr(addr_s[0]),
        .mem_wdata(wdata_s[0]), .mem_rdata(rdata_s[0]), .mem_ack(ack_s[0]), .mem_err(err_s[0]),
        .access_count(acc_s[0]), .refresh_count(ref_s[0])
    );

    gpu_mem_responder #(
        .NUM_CHANNELS(NC), .CHANNEL_WIDTH(CW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL), .REFRESH_INTERVAL(0), .REFRESH_CYCLES(RC)
    ) dut_nr (
        .clk(clk), .rst_n(rst_n), .mem_req(req_s[1]), .mem_we(we_s[1]), .mem_addr(addr_s[1]),
        .mem_wdata(wdata_s[1]), .mem_rdata(rdata_s[1]), .mem_ack(ack_s[1]), .mem_err(err_s[1]),
        .access_count(acc_s[1]), .refresh_count(ref_s[1])
    );

    typedef struct {
        logic [W-1:0] rdata;
        logic         err;
    } exp_t;

    exp_t         sb [$];
    logic [W-1:0] model [2][DEPTH];
    logic [W-1:0] last_rd [2];
    int           checks = 0;
    int           errors = 0;
    int           cyc;

    // Edges since reset release; the refresh timer expires when this reaches 64.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [W-1:0] pat(input int s);
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) begin
            v[i*32 +: 32] = (32'(s) * 32'h9E37_79B1) ^ (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000;
        end
        return v;
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_s[s] = 1'b0; we_s[s] = 1'b0; addr_s[s] = '0; wdata_s[s] = '0;
            last_rd[s] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // exp_edges: clock edges from raising mem_req to the edge that shows mem_ack.
    task automatic do_txn(input int sel, input logic we, input logic [AW-1:0] addr,
                          input logic [W-1:0] wd, input int exp_edges, input string name);
        exp_t e;
        int   idx;
        logic oor;
        int   n;
        bit   got;
        idx   = int'(addr[ALSB +: IDX_W]);
        oor   = |addr[AW-1:ALSB+IDX_W];
        e.err = oor;
        e.rdata = we ? last_rd[sel] : (oor ? '0 : model[sel][idx]);
        sb.push_back(e);
        if (we && !oor) model[sel][idx] = wd;
        if (!we) last_rd[sel] = e.rdata;

        req_s[sel] = 1'b1; we_s[sel] = we; addr_s[sel] = addr; wdata_s[sel] = wd;
        n = 0; got = 0;
        while (!got && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (ack_s[sel] === 1'b1) got = 1;
        end
        req_s[sel] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout ack=0 after %0d edges, required ack=1", name, n);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        checks++;
        if (n !== exp_edges) begin
            errors++;
            $display("FAIL %s_latency got %0d edges required %0d", name, n, exp_edges);
        end
        checks++;
        if (err_s[sel] !== e.err) begin
            errors++;
            $display("FAIL %s_err got %b required %b", name, err_s[sel], e.err);
        end
        checks++;
        if (rdata_s[sel] !== e.rdata) begin
            errors++;
            $display("FAIL %s_rdata got %h required %h", name, rdata_s[sel], e.rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (ack_s[sel] !== 1'b0 || err_s[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse got ack=%b err=%b required 0 0", name, ack_s[sel], err_s[sel]);
        end
        $display("txn %s sel=%0d we=%0d addr=%h edges=%0d err=%0d", name, sel, we, addr, n, err_s[sel]);
    endtask

    task automatic check_cnt(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (ack_s[s] !== 1'b0 || err_s[s] !== 1'b0 || rdata_s[s] !== '0) begin
                errors++;
                $display("FAIL reset_outputs sel=%0d got ack=%b err=%b rdata_or=%b required 0 0 0",
                         s, ack_s[s], err_s[s], |rdata_s[s]);
            end
            check_cnt("reset_access_count", acc_s[s], 32'd0);
            check_cnt("reset_refresh_count", ref_s[s], 32'd0);
        end
        $display("txn reset done");
    endtask

    task automatic test_write_read();
        reset_dut();
        do_txn(0, 1'b1, 40'h140, pat(1), WL + 1, "wr_idx5");
        do_txn(0, 1'b0, 40'h140, '0, RL + 2, "rd_idx5");
        check_cnt("wr_rd_access_count", acc_s[0], 32'd2);
    endtask

    task automatic test_back_to_back();
        reset_dut();
        do_txn(0, 1'b1, 40'h0,    pat(2), WL + 1, "b2b_wr_idx0");
        do_txn(0, 1'b1, 40'h3FC0, pat(3), WL + 2, "b2b_wr_idx255");
        // RL+2 edges from re-raise means captures are RL+3 = 7 cycles apart.
        do_txn(0, 1'b0, 40'h0,    '0,     RL + 2, "b2b_rd_idx0");
        do_txn(0, 1'b0, 40'h3FC0, '0,     RL + 2, "b2b_rd_idx255");
    endtask

    task automatic test_out_of_range();
        reset_dut();
        do_txn(0, 1'b1, 40'h0,    pat(4), WL + 1, "oor_wr_idx0");
        do_txn(0, 1'b0, 40'h0,    '0,     RL + 2, "oor_rd_idx0");
        do_txn(0, 1'b0, 40'h4000, '0,     RL + 2, "oor_rd");
        do_txn(0, 1'b1, 40'h4000, pat(5), WL + 2, "oor_wr");
        do_txn(0, 1'b0, 40'h17,   '0,     RL + 2, "oor_rd_lowbits");
        check_cnt("oor_access_count", acc_s[0], 32'd5);
    endtask

    task automatic test_refresh();
        reset_dut();
        do begin
            @(posedge clk); #1;
        end while (cyc < RI);
        check_cnt("refresh_before", ref_s[0], 32'd0);
        // Pending is set; idle, refresh, idle, capture, then the read latency.
        do_txn(0, 1'b0, 40'h140, '0, 1 + RC + 1 + RL, "refresh_rd_idx5");
        check_cnt("refresh_count", ref_s[0], 32'd1);
        check_cnt("refresh_access_count", acc_s[0], 32'd1);
    endtask

    task automatic test_reset_mid_txn();
        int n_ack;
        reset_dut();
        do_txn(0, 1'b1, 40'h240, pat(9), WL + 1, "mid_wr_idx9");
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 40'h240; wdata_s[0] = pat(10);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        req_s[0] = 1'b0;
        n_ack = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack_s[0] !== 1'b0) n_ack++;
        end
        check_cnt("mid_reset_acks", 32'(n_ack), 32'd0);
        check_cnt("mid_reset_access_count", acc_s[0], 32'd0);
        check_cnt("mid_reset_refresh_count", ref_s[0], 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        do_txn(0, 1'b0, 40'h240, '0, RL + 1, "mid_rd_idx9");
    endtask

    task automatic test_no_refresh();
        int first;
        reset_dut();
        first = 1;
        for (int i = 0; i < 13; i++) begin
            logic [AW-1:0] a;
            a = AW'((i * 19) % DEPTH) << ALSB;
            do_txn(1, 1'b1, a, pat(100 + i), first ? WL + 1 : WL + 2, "nr_wr");
            do_txn(1, 1'b0, a, '0, RL + 2, "nr_rd");
            first = 0;
        end
        check_cnt("nr_refresh_count", ref_s[1], 32'd0);
        check_cnt("nr_access_count", acc_s[1], 32'd26);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required finish before 200000");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_refresh();
        test_reset_mid_txn();
        test_no_refresh();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
